uart_dump: RTL and testbench

Memory-dump transmitter: the read-side counterpart of the UART download path. On a start pulse it acts as a bus master and reads a block of 32-bit words from any slave address. It then streams them out of a UART TX pin as a framed, checksummed byte sequence. It sits beside the UART download block on the same bus master port and pin group, and is selected by software or bench control through `start_i`.

---
 rtl/uart_dump_pkg.sv | 30 +++
 rtl/uart_dump_tx_byte.sv | 56 +++++
 rtl/uart_dump.sv | 156 +++++++++++++++
 tb/tb_uart_dump.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dump_pkg.sv
// Shared definitions for the memory-dump transmitter: header byte, UART frame
// length and FSM state encodings.
package uart_dump_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         FRAME_BITS = 10;

    // state    | meaning
    // ST_IDLE  | waiting for start_i
    // ST_HDR   | header byte 0xA5 on the wire
    // ST_RD    | bus read of the current word (1+RD_WAIT cycles)
    // ST_SEND  | bytes of the captured word on the wire
    // ST_CSUM  | checksum byte on the wire
    // ST_DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [31:0] w_shifted;
        w_shifted = word >> {idx, 3'b000};
        return w_shifted[7:0];
    endfunction

endpackage

// File: rtl/uart_dump_tx_byte.sv
// 8N1 byte transmitter: baud down-counter plus a 10-bit shift register.
// ready_o is also high in the last stop-bit cycle so bytes can run back-to-back.
module uart_tx_byte
    import uart_dump_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  r_active;
    logic [FRAME_BITS-1:0] r_shift;
    logic [15:0]           r_baud;
    logic [3:0]            r_bits;

    logic w_bit_end;
    logic w_last;

    assign w_bit_end = (r_baud == 16'd0);
    assign w_last    = w_bit_end && (r_bits == 4'd0);
    assign ready_o   = !r_active || w_last;
    assign tx_o      = r_active ? r_shift[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_shift  <= '1;
            r_baud   <= 16'd0;
            r_bits   <= 4'd0;
        end else if (valid_i && ready_o) begin
            r_active <= 1'b1;
            r_shift  <= {1'b1, data_i, 1'b0};
            r_baud   <= BAUD_MAX;
            r_bits   <= LAST_BIT;
        end else if (r_active) begin
            if (w_last) begin
                r_active <= 1'b0;
            end else if (w_bit_end) begin
                r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
                r_bits  <= r_bits - 4'd1;
                r_baud  <= BAUD_MAX;
            end else begin
                r_baud <= r_baud - 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_dump.sv
// Memory-dump transmitter: reads a block of words over the bus master port and
// streams them out as header, little-endian data bytes and an XOR checksum.
module uart_dump
    import uart_dump_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    output logic        tx_pin,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] WAIT_MAX = 2'(RD_WAIT);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [15:0] r_count;
    logic [7:0]  r_csum;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [1:0]  r_wait;

    state_t      w_state_nxt;
    logic        w_tx_valid;
    logic [7:0]  w_tx_data;
    logic        w_tx_ready;
    logic        w_data_byte;

    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .data_i  (w_tx_data),
        .valid_i (w_tx_valid),
        .ready_o (w_tx_ready),
        .tx_o    (tx_pin)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Each next byte is issued in the cycle the previous stop bit ends so the
    // transmitter loads it without a gap; the first data byte comes straight
    // from rdata_i in the last read cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = r_csum;
        w_data_byte = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_tx_valid  = 1'b1;
                    w_tx_data   = HDR_BYTE;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_tx_ready) begin
                    if (r_count != 16'd0) begin
                        w_state_nxt = ST_RD;
                    end else begin
                        w_tx_valid  = 1'b1;
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_RD: begin
                if (r_wait == 2'd0) begin
                    w_tx_valid  = 1'b1;
                    w_tx_data   = rdata_i[7:0];
                    w_data_byte = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_tx_ready) begin
                    if (r_idx != 2'd3) begin
                        w_tx_valid  = 1'b1;
                        w_tx_data   = byte_sel(r_word, r_idx + 2'd1);
                        w_data_byte = 1'b1;
                    end else if (r_count == 16'd1) begin
                        w_tx_valid  = 1'b1;
                        w_state_nxt = ST_CSUM;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_CSUM: begin
                if (w_tx_ready) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_count <= 16'd0;
            r_csum  <= 8'd0;
            r_word  <= 32'd0;
            r_idx   <= 2'd0;
            r_wait  <= 2'd0;
        end else begin
            if (r_state == ST_IDLE && start_i) begin
                r_addr  <= base_addr_i & ~32'h3;
                r_count <= word_cnt_i;
                r_csum  <= 8'd0;
            end
            if (w_data_byte) r_csum <= r_csum ^ w_tx_data;
            if (r_state == ST_RD) begin
                if (r_wait == 2'd0) begin
                    r_word <= rdata_i;
                    r_idx  <= 2'd0;
                end else begin
                    r_wait <= r_wait - 2'd1;
                end
            end
            if (r_state == ST_SEND && w_tx_ready) begin
                if (r_idx == 2'd3) begin
                    r_count <= r_count - 16'd1;
                    r_addr  <= r_addr + 32'd4;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
            if (w_state_nxt == ST_RD && r_state != ST_RD) r_wait <= WAIT_MAX;
        end
    end

    assign req_o   = (r_state == ST_RD);
    assign we_o    = 1'b0;
    assign wdata_o = 32'd0;
    assign addr_o  = r_addr;
    assign busy_o  = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o  = (r_state == ST_DONE);

endmodule

// File: tb/tb_uart_dump.sv
// Directed bench for uart_dump: fast instance (CLK_DIV=4) for frame content,
// slow instance (CLK_DIV=434) for bit-edge timing.
module tb_uart_dump;

    localparam int FD = 4;
    localparam int SD = 434;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_cnt_i;
    logic        req_o, we_o, tx_pin, busy_o, done_o;
    logic [31:0] addr_o, wdata_o, rdata_i;

    logic        start_s;
    logic        req_s, we_s, tx_s, busy_s, done_s;
    logic [31:0] addr_s, wdata_s, rdata_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h1000_0000: return 32'h1234_5678;
            32'hFFFF_FFF8: return 32'h1122_3344;
            32'hFFFF_FFFC: return 32'hA0B0_C0D0;
            32'h0000_0000: return 32'h0F1E_2D3C;
            32'h2000_0000: return 32'hDEAD_BEEF;
            default:       return 32'hCAFE_F00D;
        endcase
    endfunction

    // Registered-read slave: data only valid from the second request cycle.
    logic req_d = 1'b0, req_sd = 1'b0;
    always @(posedge clk) begin
        req_d  <= req_o;
        req_sd <= req_s;
    end
    assign rdata_i = req_d  ? mem_rd(addr_o) : 32'hBAD0_BAD0;
    assign rdata_s = req_sd ? mem_rd(addr_s) : 32'hBAD0_BAD0;

    uart_dump #(.CLK_DIV(FD), .RD_WAIT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_cnt_i(word_cnt_i), .req_o(req_o), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rdata_i(rdata_i), .tx_pin(tx_pin), .busy_o(busy_o),
        .done_o(done_o)
    );

    uart_dump #(.CLK_DIV(SD), .RD_WAIT(1)) dut_slow (
        .clk(clk), .rst(rst), .start_i(start_s), .base_addr_i(32'h1000_0000),
        .word_cnt_i(16'd1), .req_o(req_s), .we_o(we_s), .addr_o(addr_s),
        .wdata_o(wdata_s), .rdata_i(rdata_s), .tx_pin(tx_s), .busy_o(busy_s),
        .done_o(done_s)
    );

    // Fast-instance monitor: UART receiver, bus read log, done log.
    logic [7:0]  rx_q[$];
    logic [31:0] rd_addr_q[$];
    int          req_cycles, done_cnt, done_cyc, first_fall, rx_err, rx_cnt;
    logic        rx_busy = 1'b0, prev_req = 1'b0, done_busy;
    logic [7:0]  rx_sh;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy  = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (req_o) begin
                req_cycles++;
                if (!prev_req) rd_addr_q.push_back(addr_o);
            end
            prev_req = req_o;
            if (done_o) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy_o;
            end
            if (!rx_busy) begin
                if (tx_pin === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                    if (first_fall < 0) first_fall = cyc;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= FD + FD/2 && rx_cnt < 9*FD && (rx_cnt - FD/2) % FD == 0)
                    rx_sh = {tx_pin, rx_sh[7:1]};
                if (rx_cnt == 9*FD + FD/2) begin
                    if (tx_pin !== 1'b1) rx_err++;
                    else rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // Slow-instance monitor: tx edge times and done time.
    int   s_edges[$];
    logic s_prev = 1'b1;
    int   s_done_cyc = -1;
    always @(negedge clk) begin
        if (tx_s !== s_prev) s_edges.push_back(cyc);
        s_prev = tx_s;
        if (done_s) s_done_cyc = cyc;
    end

    task automatic clear_mon();
        rx_q.delete();
        rd_addr_q.delete();
        req_cycles = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        first_fall = -1;
        rx_err     = 0;
        done_busy  = 1'b1;
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk); #1;
        base_addr_i = base;
        word_cnt_i  = cnt;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt != 0);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; start_s = 1'b0;
        base_addr_i = 32'h0; word_cnt_i = 16'd0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_pin); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_o); end
        checks++; if (addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_vs_start_busy: got %b want 0", busy_o); end
        checks++; if (first_fall != -1) begin errors++; $display("FAIL rst_vs_start_tx: start bit at cycle %0d want none", first_fall); end
    endtask

    task automatic test_header_only();
        bit ok;
        clear_mon();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hdr_busy_pre: got %b want 0", busy_o); end
        pulse_start(32'h0000_0040, 16'd0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL hdr_busy_rise: got %b want 1", busy_o); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hdr_timeout: done_o not seen in 200 cycles"); end
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL hdr_nbytes: got %0d want 2", rx_q.size()); end
        checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL hdr_byte0: got %h want a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
        checks++; if (rx_q.size() < 2 || rx_q[1] !== 8'h00) begin errors++; $display("FAIL hdr_csum: got %h want 00", rx_q.size() > 1 ? rx_q[1] : 8'hxx); end
        checks++; if (req_cycles != 0) begin errors++; $display("FAIL hdr_req: got %0d req cycles want 0", req_cycles); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL hdr_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc - first_fall != 80) begin errors++; $display("FAIL hdr_len: got %0d want 80", done_cyc - first_fall); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL hdr_busy_at_done: got %b want 0", done_busy); end
        checks++; if (rx_err != 0) begin errors++; $display("FAIL hdr_framing: got %0d errors want 0", rx_err); end
    endtask

    task automatic test_one_word();
        bit ok;
        logic [7:0] exp_b [6] = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        clear_mon();
        pulse_start(32'h1000_0000, 16'd1);
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL one_timeout: done_o not seen in 400 cycles"); end
        checks++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 32'h1000_0000) begin
            errors++; $display("FAIL one_reads: got %0d reads first %h want 1 read of 10000000", rd_addr_q.size(), rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hx); end
        checks++; if (req_cycles != 2) begin errors++; $display("FAIL one_req_cycles: got %0d want 2", req_cycles); end
        checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL one_nbytes: got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL one_byte%0d: got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]); end
        end
        checks++; if (done_cyc - first_fall != 242) begin errors++; $display("FAIL one_len: got %0d want 242", done_cyc - first_fall); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL one_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0]  exp_b [14] = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hD0, 8'hC0, 8'hB0, 8'hA0,
                                    8'h3C, 8'h2D, 8'h1E, 8'h0F, 8'h44};
        logic [31:0] exp_a [3]  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        clear_mon();
        pulse_start(32'hFFFF_FFFB, 16'd3);
        wait_done(800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: done_o not seen in 800 cycles"); end
        checks++; if (rd_addr_q.size() != 3) begin errors++; $display("FAIL wrap_nreads: got %0d want 3", rd_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rd_addr_q.size() || rd_addr_q[i] !== exp_a[i]) begin
                errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, i < rd_addr_q.size() ? rd_addr_q[i] : 32'hx, exp_a[i]); end
        end
        checks++; if (rx_q.size() != 14) begin errors++; $display("FAIL wrap_nbytes: got %0d want 14", rx_q.size()); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]); end
        end
        checks++; if (req_cycles != 6) begin errors++; $display("FAIL wrap_req_cycles: got %0d want 6", req_cycles); end
        checks++; if (done_cyc - first_fall != 566) begin errors++; $display("FAIL wrap_len: got %0d want 566", done_cyc - first_fall); end
    endtask

    task automatic test_busy_start();
        bit ok;
        clear_mon();
        pulse_start(32'h1000_0000, 16'd1);
        repeat (50) @(posedge clk);
        #1;
        base_addr_i = 32'h2000_0000;
        word_cnt_i  = 16'd2;
        start_i     = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: done_o not seen in 400 cycles"); end
        checks++; if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 32'h1000_0000) begin
            errors++; $display("FAIL busy_reads: got %0d reads first %h want 1 read of 10000000", rd_addr_q.size(), rd_addr_q.size() > 0 ? rd_addr_q[0] : 32'hx); end
        checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL busy_nbytes: got %0d want 6", rx_q.size()); end
        checks++; if (rx_q.size() < 6 || rx_q[5] !== 8'h08) begin errors++; $display("FAIL busy_csum: got %h want 08", rx_q.size() > 5 ? rx_q[5] : 8'hxx); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc - first_fall != 242) begin errors++; $display("FAIL busy_len: got %0d want 242", done_cyc - first_fall); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int s;
        logic [7:0] exp_b [6] = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        clear_mon();
        pulse_start(32'h1000_0000, 16'd1);
        s = cyc;
        while (cyc < s + 130) @(negedge clk);
        checks++; if (tx_pin !== 1'b0) begin errors++; $display("FAIL mid_pre_tx: got %b want 0", tx_pin); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", tx_pin); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy_o); end
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", req_o); end
        repeat (300) @(negedge clk);
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt); end
        clear_mon();
        pulse_start(32'h1000_0000, 16'd1);
        wait_done(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_restart_timeout: done_o not seen in 400 cycles"); end
        checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL mid_nbytes: got %0d want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL mid_byte%0d: got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_b[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_bit_timing();
        int n = 0;
        int t0, w0, d, misaligned;
        bit found_w0;
        s_edges.delete();
        s_done_cyc = -1;
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        while (s_done_cyc < 0 && n < 27000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (s_done_cyc < 0) begin errors++; $display("FAIL slow_timeout: done_o not seen in 27000 cycles"); end
        checks++; if (s_edges.size() != 36) begin errors++; $display("FAIL slow_nedges: got %0d want 36", s_edges.size()); end
        if (s_edges.size() > 0) begin
            t0 = s_edges[0];
            w0 = t0 + 10*SD + 2;
            misaligned = 0;
            found_w0 = 1'b0;
            foreach (s_edges[i]) begin
                d = (s_edges[i] < w0) ? s_edges[i] - t0 : s_edges[i] - w0;
                if (d % SD != 0) misaligned++;
                if (s_edges[i] == w0) found_w0 = 1'b1;
            end
            checks++; if (misaligned != 0) begin errors++; $display("FAIL slow_align: got %0d off-grid edges want 0", misaligned); end
            checks++; if (!found_w0) begin errors++; $display("FAIL slow_gap: no start bit at header end + 2 cycles"); end
            checks++; if (s_done_cyc - t0 != 60*SD + 2) begin errors++; $display("FAIL slow_len: got %0d want %0d", s_done_cyc - t0, 60*SD + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_header_only();
        test_one_word();
        test_wrap();
        test_busy_start();
        test_reset_mid();
        test_bit_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
